alu_cmd_sequencer: RTL and testbench

Command-driven initiator for the 32-bit combinational ALU (`NewALU`). It accepts operation commands over a valid/ready handshake and drives the ALU operand, opcode and ior inputs. It holds them for a programmable settle time, then captures result, carry and NZCV into a response register. It also keeps an architectural flag register for conditional execution and can forward the previous result as operand A, so the datapath can chain ALU operations.

---
 rtl/alu_seq_pkg.sv | 70 +++++++
 rtl/alu_cmd_sequencer_if.sv | 37 +++
 rtl/alu_cond_eval.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer:
// opcodes, condition codes, NZCV bit positions, FSM states and register payloads.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned COND_W = 4;
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SADD = 4'b0111;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b1010;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1011;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1100;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1110;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              ior;
        logic              setflags;
    } issue_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [NZCV_W-1:0] nzcv;
        logic              carry;
        logic              executed;
        logic              illegal;
    } rsp_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_SADD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a requester (master) and the sequencer (slave).
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [DATA_W-1:0]   cmd_a;
    logic [DATA_W-1:0]   cmd_b;
    logic                cmd_ior;
    logic                cmd_use_prev;
    logic                cmd_setflags;
    logic [COND_W-1:0]   cmd_cond;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic [NZCV_W-1:0]   rsp_nzcv;
    logic                rsp_carry;
    logic                rsp_executed;
    logic                rsp_illegal;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_ior, cmd_use_prev, cmd_setflags, cmd_cond,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_nzcv, rsp_carry, rsp_executed, rsp_illegal
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_ior, cmd_use_prev, cmd_setflags, cmd_cond,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_nzcv, rsp_carry, rsp_executed, rsp_illegal
    );

endinterface

// File: rtl/alu_cond_eval.sv
// Condition-code evaluator: decides whether a command executes given the NZCV flag register.
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [NZCV_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[NZCV_N];
        z    = flags[NZCV_Z];
        c    = flags[NZCV_C];
        v    = flags[NZCV_V];
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts ALU commands, drives the combinational ALU for SETTLE_CYCLES, then captures
// result/flags into a held response; maintains the architectural NZCV and forwarded result.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_cmd_sequencer_if.slave  cmd_if,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_ior,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [NZCV_W-1:0]   alu_nzcv,
    input  logic                alu_carry,
    output logic [NZCV_W-1:0]   flags
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    issue_t             iss_q, iss_d;
    rsp_t               rsp_q, rsp_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic [NZCV_W-1:0]  flags_q, flags_d;
    logic               cond_pass;
    logic               op_legal;

    alu_cond_eval u_cond (
        .flags (flags_q),
        .cond  (cmd_if.cmd_cond),
        .pass  (cond_pass)
    );

    assign op_legal = is_legal_op(cmd_if.cmd_op);

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iss_d   = iss_q;
        rsp_d   = rsp_q;
        prev_d  = prev_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    if (op_legal && cond_pass) begin
                        iss_d.a        = cmd_if.cmd_use_prev ? prev_q : cmd_if.cmd_a;
                        iss_d.b        = cmd_if.cmd_b;
                        iss_d.op       = cmd_if.cmd_op;
                        iss_d.ior      = cmd_if.cmd_ior;
                        iss_d.setflags = cmd_if.cmd_setflags;
                        cnt_d          = CNT_W'(SETTLE_CYCLES);
                        state_d        = ST_DRIVE;
                    end else begin
                        rsp_d         = '0;
                        rsp_d.illegal = !op_legal;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_d.result   = alu_result;
                    rsp_d.nzcv     = alu_nzcv;
                    rsp_d.carry    = alu_carry;
                    rsp_d.executed = 1'b1;
                    rsp_d.illegal  = 1'b0;
                    prev_d         = alu_result;
                    if (iss_q.setflags) begin
                        flags_d = alu_nzcv;
                    end
                    iss_d.op = OP_NOP;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (cmd_if.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            iss_q            <= '0;
            rsp_q            <= '0;
            prev_q           <= '0;
            flags_q          <= '0;
            cmd_if.cmd_ready <= 1'b1;
            cmd_if.rsp_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            iss_q            <= iss_d;
            rsp_q            <= rsp_d;
            prev_q           <= prev_d;
            flags_q          <= flags_d;
            cmd_if.cmd_ready <= (state_d == ST_IDLE);
            cmd_if.rsp_valid <= (state_d == ST_RESP);
        end
    end

    assign alu_a               = iss_q.a;
    assign alu_b               = iss_q.b;
    assign alu_op              = iss_q.op;
    assign alu_ior             = iss_q.ior;
    assign flags               = flags_q;
    assign cmd_if.rsp_result   = rsp_q.result;
    assign cmd_if.rsp_nzcv     = rsp_q.nzcv;
    assign cmd_if.rsp_carry    = rsp_q.carry;
    assign cmd_if.rsp_executed = rsp_q.executed;
    assign cmd_if.rsp_illegal  = rsp_q.illegal;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: two instances (settle 1 and 4) each driving a
// behavioural ALU; checks timing, flags, conditions, forwarding, backpressure and reset abort.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset1, reset4;
    logic [3:0]  cmd_op, cmd_cond;
    logic [31:0] cmd_a, cmd_b;
    logic        cmd_ior, cmd_use_prev, cmd_setflags;
    logic        cmd_valid1, cmd_valid4, rsp_ready;

    logic [31:0] a1, b1, res1, a4, b4, res4;
    logic [3:0]  op1, nzcv1, flags1, op4, nzcv4, flags4;
    logic        ior1, car1, ior4, car4;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat;
    logic [31:0] r_result, seen_a;
    logic [3:0]  r_nzcv, seen_op;
    logic        r_carry, r_exec, r_ill, seen_ior;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if if1 ();
    alu_cmd_sequencer_if if4 ();

    assign if1.cmd_valid = cmd_valid1;
    assign if4.cmd_valid = cmd_valid4;
    assign if1.cmd_op = cmd_op;             assign if4.cmd_op = cmd_op;
    assign if1.cmd_a = cmd_a;               assign if4.cmd_a = cmd_a;
    assign if1.cmd_b = cmd_b;               assign if4.cmd_b = cmd_b;
    assign if1.cmd_ior = cmd_ior;           assign if4.cmd_ior = cmd_ior;
    assign if1.cmd_use_prev = cmd_use_prev; assign if4.cmd_use_prev = cmd_use_prev;
    assign if1.cmd_setflags = cmd_setflags; assign if4.cmd_setflags = cmd_setflags;
    assign if1.cmd_cond = cmd_cond;         assign if4.cmd_cond = cmd_cond;
    assign if1.rsp_ready = rsp_ready;       assign if4.rsp_ready = rsp_ready;

    alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset1), .cmd_if(if1.slave),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_ior(ior1),
        .alu_result(res1), .alu_nzcv(nzcv1), .alu_carry(car1), .flags(flags1)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset4), .cmd_if(if4.slave),
        .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_ior(ior4),
        .alu_result(res4), .alu_nzcv(nzcv4), .alu_carry(car4), .flags(flags4)
    );

    // Behavioural ALU: returns {carry, nzcv, result}
    function automatic logic [36:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0111, 4'b1001: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b1010: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                c = s[32];
                v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'b1011: s = {1'b0, a & b};
            4'b1100: s = {1'b0, a | b};
            4'b1101: s = {1'b0, a ^ b};
            4'b1110: s = {1'b0, ~a};
            default: s = '0;
        endcase
        r = s[31:0];
        return {c, r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {car1, nzcv1, res1} = alu_f(op1, a1, b1);
    always_comb {car4, nzcv4, res4} = alu_f(op4, a4, b4);

    // Issue one command to the selected instance and wait (bounded) for its response.
    task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ior, input logic prev, input logic setf, input logic [3:0] cond);
        bit found;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_ior = ior;
        cmd_use_prev = prev; cmd_setflags = setf; cmd_cond = cond;
        if (sel) cmd_valid4 = 1'b1; else cmd_valid1 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0; cmd_valid4 = 1'b0;
        lat = 0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                seen_op  = sel ? op4 : op1;
                seen_ior = sel ? ior4 : ior1;
                seen_a   = sel ? a4 : a1;
            end
            if (sel ? if4.rsp_valid : if1.rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) lat = 99;
        r_result = sel ? if4.rsp_result : if1.rsp_result;
        r_nzcv   = sel ? if4.rsp_nzcv : if1.rsp_nzcv;
        r_carry  = sel ? if4.rsp_carry : if1.rsp_carry;
        r_exec   = sel ? if4.rsp_executed : if1.rsp_executed;
        r_ill    = sel ? if4.rsp_illegal : if1.rsp_illegal;
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset1 = 1'b1; reset4 = 1'b1;
        cmd_valid1 = 1'b0; cmd_valid4 = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_ior = 1'b0;
        cmd_use_prev = 1'b0; cmd_setflags = 1'b0; cmd_cond = 4'hE;
        repeat (3) @(negedge clk);
        reset1 = 1'b0; reset4 = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({if1.cmd_ready, if1.rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 10", {if1.cmd_ready, if1.rsp_valid});
        end
        n_tests++;
        if ({if1.rsp_result, if1.rsp_nzcv, if1.rsp_carry, if1.rsp_executed, if1.rsp_illegal} !== 39'd0) begin
            n_fail++; $display("FAIL reset_rsp: got %h expected 0",
                               {if1.rsp_result, if1.rsp_nzcv, if1.rsp_carry, if1.rsp_executed, if1.rsp_illegal});
        end
        n_tests++;
        if ({a1, b1, op1, ior1, flags1} !== 73'd0) begin
            n_fail++; $display("FAIL reset_alu_flags: got %h expected 0", {a1, b1, op1, ior1, flags1});
        end
    endtask

    task automatic test_add();
        issue(1'b0, 4'b1001, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_tests++;
        if (r_result !== 32'h0000FFFF) begin n_fail++; $display("FAIL add_result: got %h expected 0000ffff", r_result); end
        n_tests++;
        if ({r_nzcv, r_carry, r_exec, r_ill} !== 7'b0000_0_1_0) begin
            n_fail++; $display("FAIL add_status: got %b expected 0000010", {r_nzcv, r_carry, r_exec, r_ill});
        end
        n_tests++;
        if (seen_op !== 4'b1001) begin n_fail++; $display("FAIL add_alu_op: got %b expected 1001", seen_op); end
        ack();
        n_tests++;
        if (op1 !== 4'b0000) begin n_fail++; $display("FAIL add_op_idle: got %b expected 0000", op1); end
    endtask

    task automatic test_flags();
        issue(1'b0, 4'b0111, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 4'hE);
        n_tests++;
        if ({r_result, r_nzcv, r_carry, r_exec} !== {32'h0, 4'b0110, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sadd_rsp: got %h/%b/%b/%b expected 0/0110/1/1", r_result, r_nzcv, r_carry, r_exec);
        end
        n_tests++;
        if (flags1 !== 4'b0110) begin n_fail++; $display("FAIL sadd_flags: got %b expected 0110", flags1); end
        ack();
        issue(1'b0, 4'b1001, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 4'b0000);
        n_tests++;
        if ({r_exec, r_result} !== {1'b1, 32'd8}) begin
            n_fail++; $display("FAIL cond_eq: got exec %b result %h expected 1/8", r_exec, r_result);
        end
        ack();
        issue(1'b0, 4'b1001, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        n_tests++;
        if ({r_exec, r_ill, r_result, r_nzcv} !== 38'd0) begin
            n_fail++; $display("FAIL cond_ne_skip: got exec %b ill %b result %h nzcv %b expected all 0",
                               r_exec, r_ill, r_result, r_nzcv);
        end
        n_tests++;
        if (lat !== 1) begin n_fail++; $display("FAIL cond_ne_latency: got %0d expected 1", lat); end
        n_tests++;
        if (flags1 !== 4'b0110) begin n_fail++; $display("FAIL cond_ne_flags: got %b expected 0110", flags1); end
        ack();
    endtask

    task automatic test_chain();
        issue(1'b0, 4'b1011, 32'hF0F0F0F0, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if (r_result !== 32'h0000F0F0) begin n_fail++; $display("FAIL and_result: got %h expected 0000f0f0", r_result); end
        n_tests++;
        if (seen_ior !== 1'b1) begin n_fail++; $display("FAIL and_ior: got %b expected 1", seen_ior); end
        ack();
        issue(1'b0, 4'b1100, 32'hDEADBEEF, 32'h0F000000, 1'b0, 1'b1, 1'b0, 4'hE);
        n_tests++;
        if (seen_a !== 32'h0000F0F0) begin n_fail++; $display("FAIL fwd_operand: got %h expected 0000f0f0", seen_a); end
        n_tests++;
        if (r_result !== 32'h0F00F0F0) begin n_fail++; $display("FAIL fwd_result: got %h expected 0f00f0f0", r_result); end
        ack();
    endtask

    task automatic test_backpressure();
        int bad;
        issue(1'b0, 4'b1101, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if ({r_result, r_nzcv} !== {32'hF00FF00F, 4'b1000}) begin
            n_fail++; $display("FAIL xor_rsp: got %h/%b expected f00ff00f/1000", r_result, r_nzcv);
        end
        cmd_op = 4'b1001; cmd_a = 32'd1; cmd_b = 32'd1; cmd_use_prev = 1'b0; cmd_cond = 4'hE;
        cmd_valid1 = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!(if1.rsp_valid === 1'b1 && if1.cmd_ready === 1'b0 &&
                  if1.rsp_result === 32'hF00FF00F && if1.rsp_nzcv === 4'b1000)) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid1 = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({if1.cmd_ready, if1.rsp_valid, op1} !== 6'b10_0000) begin
            n_fail++; $display("FAIL stall_release: got %b expected 100000", {if1.cmd_ready, if1.rsp_valid, op1});
        end
        issue(1'b0, 4'b1001, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if ({lat[3:0], r_result} !== {4'd2, 32'd2}) begin
            n_fail++; $display("FAIL after_stall: got lat %0d result %h expected 2/2", lat, r_result);
        end
        ack();
    endtask

    task automatic test_illegal();
        issue(1'b0, 4'b0000, 32'd7, 32'd9, 1'b0, 1'b0, 1'b1, 4'hE);
        n_tests++;
        if ({r_ill, r_exec, r_result} !== {1'b1, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL illegal_rsp: got ill %b exec %b result %h expected 1/0/0", r_ill, r_exec, r_result);
        end
        n_tests++;
        if ({lat[3:0], seen_op} !== {4'd1, 4'b0000}) begin
            n_fail++; $display("FAIL illegal_timing: got lat %0d op %b expected 1/0000", lat, seen_op);
        end
        n_tests++;
        if (flags1 !== 4'b0110) begin n_fail++; $display("FAIL illegal_flags: got %b expected 0110", flags1); end
        ack();
        issue(1'b0, 4'b1111, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if ({r_ill, r_exec} !== 2'b10) begin n_fail++; $display("FAIL illegal_f: got %b expected 10", {r_ill, r_exec}); end
        ack();
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        cmd_op = 4'b0111; cmd_a = 32'hFFFFFFFF; cmd_b = 32'd1; cmd_ior = 1'b0;
        cmd_use_prev = 1'b0; cmd_setflags = 1'b1; cmd_cond = 4'hE;
        cmd_valid4 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid4 = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({op4, if4.cmd_ready} !== 5'b0111_0) begin
            n_fail++; $display("FAIL abort_driving: got %b expected 01110", {op4, if4.cmd_ready});
        end
        #1;
        reset4 = 1'b1;
        #1;
        n_tests++;
        if ({if4.rsp_valid, if4.cmd_ready, flags4, op4} !== 10'b0_1_0000_0000) begin
            n_fail++; $display("FAIL abort_immediate: got %b expected 0100000000",
                               {if4.rsp_valid, if4.cmd_ready, flags4, op4});
        end
        @(negedge clk);
        reset4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if4.rsp_valid !== 1'b0 || flags4 !== 4'b0000) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d bad cycles expected 0", seen); end
        issue(1'b1, 4'b1001, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 4'hE);
        n_tests++;
        if ({lat[3:0], r_result, r_exec} !== {4'd5, 32'd5, 1'b1}) begin
            n_fail++; $display("FAIL settle4: got lat %0d result %h exec %b expected 5/5/1", lat, r_result, r_exec);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags();
        test_chain();
        test_backpressure();
        test_illegal();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
